// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    // Receiver FSM states. PARITY exists only when UART_RX_PARITY_EN is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int UART_OVS    = 16;
    localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_sync_edge.sv
// Multi-stage synchroniser for the asynchronous serial line plus a
// falling-edge detector on the synchronised level. All flops reset to 1,
// which is the idle line level, so no edge appears when reset is released.
module uart_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic rx_i,
    output logic rx_s,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s_q;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Remember the previous synchronised level for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s_q <= 1'b1;
        end else begin
            rx_s_q <= rx_s;
        end
    end

    assign fall_o = rx_s_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 deserialiser with a one-entry holding
// register and valid/read handshake.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit (8E1) and the
// parity_err_o output.
//
// Handshake: data_valid_o is a level meaning data_o holds an unread byte.
// rd_i while data_valid_o=1 clears it on the next edge; rd_i while
// data_valid_o=0 is ignored. A byte completing in the same cycle as rd_i
// loads and keeps data_valid_o high without an overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int OVS         = UART_OVS,
    parameter int SYNC_STAGES = 2
) (
    input  logic              uart_clk_i,
    input  logic              uart_rst_n_i,
    input  logic              rx_clk_en_i,
    input  logic              rx_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              framing_err_o,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err_o,
`endif
    output logic              overrun_err_o
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    logic              rx_s;
    logic              fall;
    rx_state_t         state;
    logic [TW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_q;
`ifdef UART_RX_PARITY_EN
    logic              par_bit_q;
    logic              par_bad;
    assign par_bad = par_bit_q ^ (^shift_q);
`endif

    uart_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (uart_clk_i),
        .rst_n_i(uart_rst_n_i),
        .rx_i   (rx_i),
        .rx_s   (rx_s),
        .fall_o (fall)
    );

    // Frame FSM, counters, shift register, holding register and error pulses.
    always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
        if (!uart_rst_n_i) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_q       <= '0;
            data_o        <= '0;
            data_valid_o  <= 1'b0;
            framing_err_o <= 1'b0;
            overrun_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
            parity_err_o  <= 1'b0;
`endif
        end else begin
            framing_err_o <= 1'b0;
            overrun_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o  <= 1'b0;
`endif
            // Consumer read; a load later in this block takes precedence.
            if (rd_i && data_valid_o) begin
                data_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Edge detection runs every cycle, not just on ticks.
                    if (fall) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end

                START: begin
                    if (rx_clk_en_i) begin
                        if (tick_cnt == TICK_HALF) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            // A high level at mid start bit means a glitch.
                            state    <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (rx_clk_en_i) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            shift_q  <= {rx_s, shift_q[DATA_W-1:1]};
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (rx_clk_en_i) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            par_bit_q <= rx_s;
                            state     <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (rx_clk_en_i) begin
                        if (tick_cnt == TICK_LAST) begin
                            // Leave at mid-stop so a short stop bit still lets
                            // the next start edge be seen.
                            tick_cnt <= '0;
                            state    <= IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_err_o <= par_bad;
`endif
                            if (!rx_s) begin
                                framing_err_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_bad) begin
                                // Bad parity: byte dropped like a framing error.
`endif
                            end else if (!data_valid_o || rd_i) begin
                                data_o       <= shift_q;
                                data_valid_o <= 1'b1;
                            end else begin
                                overrun_err_o <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Local tick generator stands in for baud_rate_gen with a
// short divider so a frame is 16*DIV clock cycles per bit.
// Compile with +define+UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

    localparam int DIV     = 4;
    localparam int BIT_CYC = 16 * DIV;

    // Event kinds carried in exp_q[9:8].
    localparam logic [1:0] EV_DATA = 2'd0;
    localparam logic [1:0] EV_FRM  = 2'd1;
    localparam logic [1:0] EV_OVR  = 2'd2;
    localparam logic [1:0] EV_PAR  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_clk_en = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_err;
    logic       overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    logic [9:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         div_cnt = 0;
    logic       dv_prev = 1'b0;

    uart_rx dut (
        .uart_clk_i   (clk),
        .uart_rst_n_i (rst_n),
        .rx_clk_en_i  (rx_clk_en),
        .rx_i         (rx),
        .rd_i         (rd),
        .data_o       (data),
        .data_valid_o (data_valid),
        .framing_err_o(framing_err),
`ifdef UART_RX_PARITY_EN
        .parity_err_o (parity_err),
`endif
        .overrun_err_o(overrun_err)
    );

    // ---------------- clock / tick generation ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        div_cnt   <= (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
        rx_clk_en <= (div_cnt == DIV - 1);
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input logic [1:0] kind, input logic [7:0] val);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, expected none at %0t",
                     kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e[9:8]));
            if (kind == EV_DATA || kind == EV_OVR)
                check("event_data", 32'(val), 32'(e[7:0]));
        end
    endtask

    // Monitor: every DUT output event is matched against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid && !dv_prev) pop_check(EV_DATA, data);
            if (framing_err)            pop_check(EV_FRM, 8'h00);
            if (overrun_err)            pop_check(EV_OVR, data);
`ifdef UART_RX_PARITY_EN
            if (parity_err)             pop_check(EV_PAR, 8'h00);
`endif
            dv_prev <= data_valid;
        end else begin
            dv_prev <= 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_cyc(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par) begin end
`endif
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    // Good frame with correct even parity.
    task automatic send_ok(input logic [7:0] b);
        send_frame(b, ^b, 1'b1);
    endtask

    task automatic do_read();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("valid_clear_after_rd", 32'(data_valid), 32'd0);
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wait_cyc(5);
        check("reset_data", 32'(data), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_frm", 32'(framing_err), 32'd0);
        check("reset_ovr", 32'(overrun_err), 32'd0);
        rst_n = 1'b1;
        wait_cyc(BIT_CYC);

        // 1: single frame 0xA5, then read.
        exp_q.push_back({EV_DATA, 8'hA5});
        send_ok(8'hA5);
        wait_cyc(BIT_CYC);
        check_drained("t1_events");
        check("t1_data", 32'(data), 32'hA5);
        check("t1_valid", 32'(data_valid), 32'd1);
        do_read();

        // 2: back-to-back 0x00, 0xFF without read -> overrun, 0x00 retained.
        exp_q.push_back({EV_DATA, 8'h00});
        send_ok(8'h00);
        exp_q.push_back({EV_OVR, 8'h00});
        send_ok(8'hFF);
        wait_cyc(BIT_CYC);
        check_drained("t2_events");
        check("t2_data_kept", 32'(data), 32'h00);
        do_read();

        // 3: 3-tick glitch on idle line, then 0x3C.
        rx = 1'b0;
        wait_cyc(3 * DIV);
        rx = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check("t3_no_valid", 32'(data_valid), 32'd0);
        check_drained("t3_glitch_events");
        exp_q.push_back({EV_DATA, 8'h3C});
        send_ok(8'h3C);
        wait_cyc(BIT_CYC);
        check_drained("t3_events");
        check("t3_data", 32'(data), 32'h3C);
        do_read();

        // 4: 0x55 with low stop, line held low 2 frames -> one framing error.
        exp_q.push_back({EV_FRM, 8'h00});
        send_frame(8'h55, ^8'h55, 1'b0);
        rx = 1'b0;
        wait_cyc(20 * BIT_CYC);
        rx = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check_drained("t4_break_events");
        check("t4_no_valid", 32'(data_valid), 32'd0);
        exp_q.push_back({EV_DATA, 8'h81});
        send_ok(8'h81);
        wait_cyc(BIT_CYC);
        check_drained("t4_events");
        check("t4_data", 32'(data), 32'h81);
        check("t4_valid", 32'(data_valid), 32'd1);

        // 5: reset in the middle of 0x7E data bits (0x81 still unread).
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h7E >> i));
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(data), 32'd0);
        check("t5_rst_valid", 32'(data_valid), 32'd0);
        rx = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(BIT_CYC);
        check_drained("t5_abort_events");
        exp_q.push_back({EV_DATA, 8'h12});
        send_ok(8'h12);
        wait_cyc(BIT_CYC);
        check_drained("t5_events");
        check("t5_data", 32'(data), 32'h12);
        do_read();

`ifdef UART_RX_PARITY_EN
        // 6: 0x03 with good parity, then with bad parity.
        exp_q.push_back({EV_DATA, 8'h03});
        send_frame(8'h03, 1'b0, 1'b1);
        wait_cyc(BIT_CYC);
        check_drained("t6_good_events");
        check("t6_data", 32'(data), 32'h03);
        do_read();
        exp_q.push_back({EV_PAR, 8'h00});
        send_frame(8'h03, 1'b1, 1'b1);
        wait_cyc(BIT_CYC);
        check_drained("t6_bad_events");
        check("t6_no_valid", 32'(data_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
